// File: rtl/float_sort4.sv
// Collects four IEEE754 single-precision words, sorts them with a six-step
// bubble network (one compare-exchange per cycle) and streams them out.
module float_sort4 #(
    parameter bit DESCENDING = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  load_cnt_q, load_cnt_d;
    logic [2:0]  step_q, step_d;
    logic [1:0]  drain_q, drain_d;
    logic [31:0] slot_q [4];
    logic [31:0] slot_d [4];
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [1:0]  lo_idx, hi_idx;
    logic        do_swap;

    // Sign-magnitude "a strictly greater than b"; NaN/Inf fall out of the bit rules.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return b[31];
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    // Pair schedule (0,1),(1,2),(2,3),(0,1),(1,2),(0,1) is a full bubble sort of 4.
    always_comb begin
        case (step_q)
            3'd1, 3'd4: lo_idx = 2'd1;
            3'd2:       lo_idx = 2'd2;
            default:    lo_idx = 2'd0;
        endcase
        hi_idx  = lo_idx + 2'd1;
        do_swap = DESCENDING ? fp_gt(slot_q[hi_idx], slot_q[lo_idx])
                             : fp_gt(slot_q[lo_idx], slot_q[hi_idx]);
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        step_d      = step_q;
        drain_d     = drain_q;
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    slot_d[load_cnt_q] = in_data;
                    load_cnt_d         = load_cnt_q + 2'd1;
                    if (load_cnt_q == 2'd3) begin
                        state_d = SORT;
                        step_d  = 3'd0;
                    end
                end
            end
            SORT: begin
                if (do_swap) begin
                    slot_d[lo_idx] = slot_q[hi_idx];
                    slot_d[hi_idx] = slot_q[lo_idx];
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd5) begin
                    // Present slot 0 including the result of the final exchange.
                    state_d     = DRAIN;
                    step_d      = 3'd0;
                    drain_d     = 2'd0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_data_d  = slot_d[0];
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (drain_q == 2'd3) begin
                        state_d     = LOAD;
                        load_cnt_d  = 2'd0;
                        drain_d     = 2'd0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        drain_d    = drain_q + 2'd1;
                        out_data_d = slot_q[drain_d];
                        out_last_d = (drain_d == 2'd3);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            load_cnt_q  <= 2'd0;
            step_q      <= 3'd0;
            drain_q     <= 2'd0;
            out_data_q  <= 32'h0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            step_q      <= step_d;
            drain_q     <= drain_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Slot storage is never observable before being rewritten, so it has no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == SORT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_float_sort4.sv
// Directed, table-driven bench for float_sort4: one ascending and one
// descending instance share the same stimulus.
module tb_float_sort4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [31:0] out_data_a;
    logic        in_ready_d, out_valid_d, out_last_d, busy_d;
    logic [31:0] out_data_d;

    always #5 clk = ~clk;

    float_sort4 #(.DESCENDING(1'b0)) u_asc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a)
    );

    float_sort4 #(.DESCENDING(1'b1)) u_desc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
        .in_data(in_data), .out_valid(out_valid_d), .out_ready(out_ready),
        .out_data(out_data_d), .out_last(out_last_d), .busy(busy_d)
    );

    typedef struct {
        logic [31:0] in   [4];
        logic [31:0] asc  [4];
        logic [31:0] desc [4];
    } vec_t;

    vec_t vecs [6];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) chk("in_ready timeout", 32'(in_ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // hold=1 keeps in_valid high with a junk word during SORT/DRAIN.
    task automatic send_group(input int v, input int first, input bit hold);
        for (int k = first; k < 4; k++) send_word(vecs[v].in[k]);
        if (hold) in_data = 32'h7F800000;
        else      in_valid = 1'b0;
    endtask

    task automatic check_latency(input int v);
        int lat = 1, nbusy = 0, nrdy = 0;
        while (!out_valid_a && lat < 20) begin
            if (busy_a) nbusy++;
            if (in_ready_a || in_ready_d) nrdy++;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", v), lat, 7);
        chk($sformatf("v%0d busy cycles", v), nbusy, 6);
        chk($sformatf("v%0d in_ready during sort", v), nrdy, 0);
    endtask

    task automatic recv_group(input int v, input int stall, input bit hold, input int nxt);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] lst;
            lst = (k == 3) ? 32'd1 : 32'd0;
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                chk($sformatf("v%0d w%0d stall%0d data", v, k, s), out_data_a, vecs[v].asc[k]);
                chk($sformatf("v%0d w%0d stall%0d last", v, k, s), 32'(out_last_a), lst);
                chk($sformatf("v%0d w%0d stall%0d valid", v, k, s), 32'(out_valid_a), 32'd1);
                chk($sformatf("v%0d w%0d stall%0d in_ready", v, k, s), 32'(in_ready_a), 32'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            if (hold && k == 3) in_data = vecs[nxt].in[0];
            chk($sformatf("v%0d w%0d valid", v, k), 32'(out_valid_a), 32'd1);
            chk($sformatf("v%0d w%0d asc data", v, k), out_data_a, vecs[v].asc[k]);
            chk($sformatf("v%0d w%0d asc last", v, k), 32'(out_last_a), lst);
            chk($sformatf("v%0d w%0d desc valid", v, k), 32'(out_valid_d), 32'd1);
            chk($sformatf("v%0d w%0d desc data", v, k), out_data_d, vecs[v].desc[k]);
            chk($sformatf("v%0d w%0d desc last", v, k), 32'(out_last_d), lst);
            chk($sformatf("v%0d w%0d in_ready", v, k), 32'(in_ready_a), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        chk($sformatf("v%0d post in_ready", v), 32'(in_ready_a), 32'd1);
        chk($sformatf("v%0d post valid", v), 32'(out_valid_a), 32'd0);
        chk($sformatf("v%0d post last", v), 32'(out_last_a), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready_a), 32'd1);
        chk({tag, " out_valid"}, 32'(out_valid_a), 32'd0);
        chk({tag, " out_last"}, 32'(out_last_a), 32'd0);
        chk({tag, " busy"}, 32'(busy_a), 32'd0);
        chk({tag, " out_data"}, out_data_a, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].in   = '{32'h40400000, 32'hBF800000, 32'h3F000000, 32'h40000000};
        vecs[0].asc  = '{32'hBF800000, 32'h3F000000, 32'h40000000, 32'h40400000};
        vecs[0].desc = '{32'h40400000, 32'h40000000, 32'h3F000000, 32'hBF800000};
        vecs[1].in   = '{32'h00000000, 32'h80000000, 32'hC0000000, 32'hBF800000};
        vecs[1].asc  = '{32'hC0000000, 32'hBF800000, 32'h80000000, 32'h00000000};
        vecs[1].desc = '{32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0000000};
        vecs[2].in   = '{32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'hFFC00000};
        vecs[2].asc  = '{32'hFFC00000, 32'hFF800000, 32'h7F800000, 32'h7FC00000};
        vecs[2].desc = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'hFFC00000};
        vecs[3].in   = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000};
        vecs[3].asc  = '{32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[3].desc = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000};
        vecs[4].in   = '{32'h00000001, 32'h80000001, 32'h7F7FFFFF, 32'hFF7FFFFF};
        vecs[4].asc  = '{32'hFF7FFFFF, 32'h80000001, 32'h00000001, 32'h7F7FFFFF};
        vecs[4].desc = '{32'h7F7FFFFF, 32'h00000001, 32'h80000001, 32'hFF7FFFFF};
        vecs[5].in   = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[5].asc  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[5].desc = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Table of independent groups, full-rate output.
        for (int v = 0; v < 5; v++) begin
            send_group(v, 0, 1'b0);
            check_latency(v);
            recv_group(v, 0, 1'b0, 0);
        end

        // Backpressure: 3 stall cycles on every output word.
        send_group(0, 0, 1'b0);
        check_latency(0);
        recv_group(0, 3, 1'b0, 0);

        // Reset mid-SORT at t+3, then a fresh group.
        send_group(0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("midsort busy before reset", 32'(busy_a), 32'd1);
        pulse_reset();
        check_idle("midsort reset");
        send_group(5, 0, 1'b0);
        check_latency(5);
        recv_group(5, 0, 1'b0, 0);

        // Reset mid-LOAD: two words discarded, next word is slot 0.
        send_word(vecs[1].in[0]);
        send_word(vecs[1].in[1]);
        in_valid = 1'b0;
        pulse_reset();
        check_idle("midload reset");
        send_group(0, 0, 1'b0);
        check_latency(0);
        recv_group(0, 0, 1'b0, 0);

        // Reset mid-DRAIN after one output word.
        send_group(2, 0, 1'b0);
        check_latency(2);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        pulse_reset();
        out_ready = 1'b1;
        check_idle("middrain reset");
        send_group(3, 0, 1'b0);
        check_latency(3);
        recv_group(3, 0, 1'b0, 0);

        // Back-to-back groups with in_valid held high throughout.
        send_group(4, 0, 1'b1);
        check_latency(4);
        recv_group(4, 0, 1'b1, 1);
        @(posedge clk);
        @(negedge clk);
        send_group(1, 1, 1'b0);
        check_latency(1);
        recv_group(1, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/float_sort4.md
FLOAT_SORT4 -- requirements
Module: float_sort4

Interface
REQ-001 Parameter DESCENDING, default 0, output order select (0 = ascending, 1 = descending).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_data carries an IEEE754 single-precision word.
REQ-005 in_ready  output  1  block can accept an input word this cycle.
REQ-006 in_data  input  32  IEEE754 single-precision input word.
REQ-007 out_valid  output  1  out_data holds a sorted word.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  32  sorted IEEE754 word, registered.
REQ-010 out_last  output  1  high with the 4th (final) word of a sorted group.
REQ-011 busy  output  1  high during SORT state.

Function
REQ-012 Transfer on an interface SHALL occur only in a cycle where valid and ready are both high.
REQ-013 FSM states SHALL be LOAD, SORT and DRAIN; reset state is LOAD.
REQ-014 LOAD: in_ready=1; accepted words SHALL be stored in slots 0..3 in arrival order via a 2-bit load counter; the 4th accepted word SHALL move the FSM to SORT on the next edge.
REQ-015 SORT: in_ready=0, busy=1, for exactly 6 cycles; step counter 0..5 SHALL apply one compare-exchange per cycle on slot pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
REQ-016 Order relation: sign-magnitude ordering; different signs -> negative is smaller (-0.0 < +0.0); both positive -> larger {exponent,mantissa} is larger; both negative -> larger {exponent,mantissa} is smaller; identical bit patterns are equal.
REQ-017 NaN/Inf SHALL be ordered purely by REQ-016 bit rules, no special casing (positive NaNs largest, negative NaNs smallest).
REQ-018 Compare-exchange SHALL swap only when the lower slot is strictly greater (DESCENDING=0) or strictly smaller (DESCENDING=1); equal words never swap (stable).
REQ-019 After step 5 the FSM SHALL enter DRAIN with out_valid=1, out_data=slot 0, out_last=0.
REQ-020 Latency: 4th word accepted at edge t -> busy high cycles t+1..t+6 -> out_valid first high in cycle t+7.
REQ-021 DRAIN: each accepted output SHALL advance a 2-bit drain index and load the next slot into out_data on the same edge; out_last=1 exactly while slot 3 is presented.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 Acceptance of the slot-3 word SHALL clear out_valid and out_last and return the FSM to LOAD with in_ready=1 on the next cycle; no input is accepted in DRAIN.
REQ-024 in_valid during SORT/DRAIN SHALL be ignored without data loss to the block's state.
REQ-025 Slot contents are bit-exact copies of inputs; no word is modified, dropped or duplicated.

Reset
REQ-026 rst high at a rising edge SHALL force LOAD, load/step/drain counters to 0, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=32'h0.
REQ-027 Reset mid-LOAD, mid-SORT or mid-DRAIN SHALL discard the partial group; the next accepted word is slot 0 of a new group.
REQ-028 Slot storage need not be cleared by reset; it SHALL not be observable before being rewritten.

Verification
REQ-029 Ascending: inputs 0x40400000(3.0), 0xBF800000(-1.0), 0x3F000000(0.5), 0x40000000(2.0), out_ready=1 -> outputs 0xBF800000, 0x3F000000, 0x40000000, 0x40400000, out_last on 4th, first out_valid 7 cycles after 4th accept.
REQ-030 Signed zero/negatives: 0x00000000, 0x80000000, 0xC0000000(-2.0), 0xBF800000(-1.0) -> 0xC0000000, 0xBF800000, 0x80000000, 0x00000000.
REQ-031 Backpressure: out_ready low 3 cycles on each word -> out_data/out_last stable while stalled, same order as REQ-029, in_ready=0 until final accept.
REQ-032 Reset mid-SORT (cycle t+3) -> next cycle in_ready=1, out_valid=0, busy=0; new group 4x 0x3F800000 -> four 0x3F800000 outputs.
REQ-033 DESCENDING=1 with REQ-029 inputs -> 0x40400000, 0x40000000, 0x3F000000, 0xBF800000.
REQ-034 Back-to-back groups with in_valid held high -> no word accepted during SORT/DRAIN, second group sorted independently.
